fft_seq_ctrl: RTL and testbench

- Top-level sequencer for the 8-point memory-based FFT datapath.
- Sits directly upstream of the dual-bank address generation unit and drives its control inputs: sel_wr, cstate_wr, cstate_rd, cnt and cnt_data.
- Loads 8 input samples, then runs 3 radix-2 stages. Each stage is a read sub-phase, a butterfly drain wait, then a write sub-phase.
- Finishes with an 8-cycle output unload and a done pulse.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_phase_cnt.sv | 32 +++
 rtl/fft_seq_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the 8-point memory-based FFT: address-generator state codes,
// transform size and the sequencer's master FSM state type.
package fft_pkg;

  localparam int unsigned N_PT   = 8;
  localparam int unsigned LOG2_N = 3;
  localparam int unsigned CNT_W  = LOG2_N;
  localparam int unsigned DCNT_W = LOG2_N + 1;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned K_W    = 2;

  // State codes shared with the dual-bank address generation unit
  localparam logic [CODE_W-1:0] CS_PRE_IN  = 4'b0000;
  localparam logic [CODE_W-1:0] CS_IDLE    = 4'b1000;
  localparam logic [CODE_W-1:0] CS_RUN     = 4'b1001;
  localparam logic [CODE_W-1:0] CS_STAGE_1 = 4'b0001;
  localparam logic [CODE_W-1:0] CS_STAGE_2 = 4'b0010;
  localparam logic [CODE_W-1:0] CS_STAGE_3 = 4'b0011;
  localparam logic [CODE_W-1:0] CS_STAGE_4 = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_UNLOAD
  } seq_state_e;

  // Butterfly stage k (1..3) maps directly onto STAGE_1..STAGE_3
  function automatic logic [CODE_W-1:0] stage_code(input logic [K_W-1:0] k);
    return CODE_W'(k);
  endfunction

endpackage

// File: rtl/fft_phase_cnt.sv
// 3-bit wrapping phase counter with clear, load, hold and terminal-count flag.
// DOWN=0 counts up with terminal count at 7; DOWN=1 counts down with terminal count at 0.
module fft_phase_cnt
  import fft_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold) begin
      r_cnt <= DOWN ? (r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tc_c = DOWN ? (r_cnt == '0) : (r_cnt == CNT_W'(N_PT - 1));

endmodule

// File: rtl/fft_seq_ctrl.sv
// Top-level sequencer for the 8-point FFT: load, three read/wait/write stages, unload.
// Optional SEQ_CTRL_STALL_EN adds an i_stall input that freezes progress and mutes strobes.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned BF_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
`ifdef SEQ_CTRL_STALL_EN
  input  logic              i_stall,
`endif
  output logic [CODE_W-1:0] o_cstate_wr,
  output logic [CODE_W-1:0] o_cstate_rd,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [DCNT_W-1:0] o_cnt_data,
  output logic              o_sel_wr,
  output logic              o_rd_en,
  output logic              o_wr_en,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned N_STAGE = LOG2_N;

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    w_k_nxt;
  logic [DCNT_W-1:0] r_acc;
  logic [DCNT_W-1:0] w_acc_nxt;
  logic              w_accept;
  logic              w_done_nxt;
  logic              w_stall;
  logic              w_cnt_tc;
  logic              w_cnt_run;
  logic              w_cnt_clr;
  logic              w_cnt_hold;
  logic              w_wait_tc;
  logic              w_wait_load;
  logic              w_wait_hold;
  logic [CNT_W-1:0]  w_unused_wait_val;
  logic [CODE_W-1:0] w_cs_wr;
  logic [CODE_W-1:0] w_cs_rd;
  logic              w_sel_wr;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_out_valid;

`ifdef SEQ_CTRL_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  // Sub-phase counter: advances only in the read, write and unload phases
  assign w_cnt_run  = (r_state == ST_RD) || (r_state == ST_WR) || (r_state == ST_UNLOAD);
  assign w_cnt_clr  = i_rst || (r_state == ST_IDLE);
  assign w_cnt_hold = !w_cnt_run || w_stall;

  fft_phase_cnt #(
    .DOWN (1'b0)
  ) u_phase_cnt (
    .i_clk      (i_clk),
    .i_clr      (w_cnt_clr),
    .i_hold     (w_cnt_hold),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_cnt      (o_cnt),
    .o_tc_c     (w_cnt_tc)
  );

  // Butterfly drain timer: loaded on the last read, expires after BF_LAT wait cycles
  assign w_wait_load = (r_state == ST_RD) && w_cnt_tc && !w_stall;
  assign w_wait_hold = (r_state != ST_WAIT) || w_stall;

  fft_phase_cnt #(
    .DOWN (1'b1)
  ) u_wait_cnt (
    .i_clk      (i_clk),
    .i_clr      (i_rst),
    .i_hold     (w_wait_hold),
    .i_load     (w_wait_load),
    .i_load_val (CNT_W'(BF_LAT - 1)),
    .o_cnt      (w_unused_wait_val),
    .o_tc_c     (w_wait_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_k     <= K_W'(1);
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_acc_nxt   = r_acc;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    w_cs_wr     = CS_IDLE;
    w_cs_rd     = CS_IDLE;
    w_sel_wr    = 1'b0;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_out_valid = 1'b0;

    if (!w_stall) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_LOAD;
            w_k_nxt     = K_W'(1);
            w_acc_nxt   = '0;
          end
        end
        ST_LOAD: begin
          // Stay one extra cycle after the 8th sample so its write is presented
          if (r_acc == DCNT_W'(N_PT)) begin
            w_state_nxt = ST_RD;
          end else if (i_in_valid) begin
            w_accept  = 1'b1;
            w_acc_nxt = r_acc + DCNT_W'(1);
          end
        end
        ST_RD: begin
          w_acc_nxt = '0;
          if (w_cnt_tc) begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_wait_tc) begin
            w_state_nxt = ST_WR;
          end
        end
        ST_WR: begin
          if (w_cnt_tc) begin
            if (r_k == K_W'(N_STAGE)) begin
              w_state_nxt = ST_UNLOAD;
            end else begin
              w_state_nxt = ST_RD;
              w_k_nxt     = r_k + K_W'(1);
            end
          end
        end
        ST_UNLOAD: begin
          if (w_cnt_tc) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    // Output decode from the upcoming state so registered outputs line up with it
    case (w_state_nxt)
      ST_LOAD: begin
        w_cs_wr  = CS_RUN;
        w_sel_wr = 1'b1;
        w_wr_en  = w_accept;
      end
      ST_RD: begin
        w_cs_rd = stage_code(w_k_nxt);
        w_rd_en = 1'b1;
      end
      ST_WAIT: begin
        w_cs_rd = stage_code(w_k_nxt);
      end
      ST_WR: begin
        w_cs_wr  = stage_code(w_k_nxt);
        w_sel_wr = 1'b1;
        w_wr_en  = 1'b1;
      end
      ST_UNLOAD: begin
        w_cs_rd     = CS_STAGE_4;
        w_rd_en     = 1'b1;
        w_out_valid = 1'b1;
      end
      default: begin
      end
    endcase

    if (w_stall) begin
      w_rd_en     = 1'b0;
      w_wr_en     = 1'b0;
      w_out_valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cstate_wr <= CS_IDLE;
      o_cstate_rd <= CS_IDLE;
      o_cnt_data  <= '0;
      o_sel_wr    <= 1'b0;
      o_rd_en     <= 1'b0;
      o_wr_en     <= 1'b0;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_cstate_wr <= w_cs_wr;
      o_cstate_rd <= w_cs_rd;
      o_sel_wr    <= w_sel_wr;
      o_rd_en     <= w_rd_en;
      o_wr_en     <= w_wr_en;
      o_out_valid <= w_out_valid;
      o_busy      <= (w_state_nxt != ST_IDLE);
      o_done      <= w_done_nxt;
      // Shows the index of the sample being written; 8 appears only on the first read cycle
      if (!w_stall) begin
        o_cnt_data <= (r_state == ST_LOAD) ? r_acc : '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: BF_LAT=2 and BF_LAT=5 instances share stimulus and are checked
// cycle by cycle against a timeline model; SEQ_CTRL_STALL_EN also exercises stall.
module tb_fft_seq_ctrl;

  localparam logic [3:0] C_IDLE = 4'b1000;
  localparam logic [3:0] C_RUN  = 4'b1001;
  localparam logic [3:0] C_ST4  = 4'b0100;

  logic clk = 1'b0;
  logic rst, start, in_valid, stall;

  logic [3:0] cw2, cr2, cd2, cw5, cr5, cd5;
  logic [2:0] cnt2, cnt5;
  logic sel2, rd2, wr2, ov2, busy2, done2;
  logic sel5, rd5, wr5, ov5, busy5, done5;
  logic [20:0] v2, v5;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.BF_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
`ifdef SEQ_CTRL_STALL_EN
    .i_stall(stall),
`endif
    .o_cstate_wr(cw2), .o_cstate_rd(cr2), .o_cnt(cnt2), .o_cnt_data(cd2),
    .o_sel_wr(sel2), .o_rd_en(rd2), .o_wr_en(wr2), .o_out_valid(ov2),
    .o_busy(busy2), .o_done(done2)
  );

  fft_seq_ctrl #(.BF_LAT(5)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
`ifdef SEQ_CTRL_STALL_EN
    .i_stall(stall),
`endif
    .o_cstate_wr(cw5), .o_cstate_rd(cr5), .o_cnt(cnt5), .o_cnt_data(cd5),
    .o_sel_wr(sel5), .o_rd_en(rd5), .o_wr_en(wr5), .o_out_valid(ov5),
    .o_busy(busy5), .o_done(done5)
  );

  assign v2 = {cw2, cr2, cnt2, cd2, sel2, rd2, wr2, ov2, busy2, done2};
  assign v5 = {cw5, cr5, cnt5, cd5, sel5, rd5, wr5, ov5, busy5, done5};

  function automatic logic [20:0] pk(input logic [3:0] cw, input logic [3:0] cr,
                                     input logic [2:0] cn, input logic [3:0] cd,
                                     input logic sel, input logic rd, input logic wr,
                                     input logic ov, input logic bsy, input logic dn);
    return {cw, cr, cn, cd, sel, rd, wr, ov, bsy, dn};
  endfunction

  // Expected outputs t cycles after the first read cycle, from the phase schedule
  function automatic logic [20:0] run_exp(input int t, input int b);
    int per, lat, s, r;
    per = 16 + b;
    lat = 3 * per + 8;
    if (t > lat)
      return pk(C_IDLE, C_IDLE, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (t == lat)
      return pk(C_IDLE, C_IDLE, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (t >= 3 * per)
      return pk(C_IDLE, C_ST4, 3'(t - 3 * per), 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    s = t / per + 1;
    r = t % per;
    if (r < 8)
      return pk(C_IDLE, 4'(s), 3'(r), (t == 0) ? 4'd8 : 4'd0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    if (r < 8 + b)
      return pk(C_IDLE, 4'(s), 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    return pk(4'(s), C_IDLE, 3'(r - 8 - b), 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [20:0] e2, input logic [20:0] e5);
    chk({tag, "/bf2"}, 32'(v2), 32'(e2));
    chk({tag, "/bf5"}, 32'(v5), 32'(e5));
    chk({tag, "/excl"}, 32'((rd2 & wr2) | (rd5 & wr5)), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One transform: random-gap load, then the run timeline with optional abort or stall
  task automatic do_xfer(input int abort_t, input int stall_t, input int stall_n);
    int n, t, sc, rd0, dn2, dn5, it;
    logic v, stl;
    logic [20:0] e, e2, e5, idle;
    idle = pk(C_IDLE, C_IDLE, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0; t = 0; sc = 0; dn2 = -1; dn5 = -1;
    in_valid = 1'($urandom);
    start = 1'b1;
    tick();
    start = 1'($urandom);
    e = pk(C_RUN, C_IDLE, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_both("load0", e, e);
    it = 0;
    while (n < 8) begin
      v = (it > 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_valid = v;
      tick();
      it++;
      e = pk(C_RUN, C_IDLE, 3'd0, 4'(n), 1'b1, 1'b0, v, 1'b0, 1'b1, 1'b0);
      if (v) n++;
      check_both("load", e, e);
    end
    in_valid = 1'($urandom);
    tick();
    rd0 = cyc;
    check_both("rd0", run_exp(0, 2), run_exp(0, 5));
    it = 0;
    while (t <= 3 * 21 + 8 && it < 400) begin
      it++;
      if (t == abort_t) begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; stall = 1'b0;
        tick();
        rst = 1'b0;
        check_both("abort", idle, idle);
        repeat (3) begin
          in_valid = 1'($urandom);
          tick();
          check_both("postabort", idle, idle);
        end
        in_valid = 1'b0;
        return;
      end
      stl = (t == stall_t) && (sc < stall_n);
      stall = stl;
      in_valid = 1'($urandom);
      start = (t < 50) ? 1'($urandom) : 1'b0;
      tick();
      if (stl) sc++;
      else t++;
      e2 = run_exp(t, 2);
      e5 = run_exp(t, 5);
      if (stl) begin
        e2 = e2 & ~21'h1C;
        e5 = e5 & ~21'h1C;
      end
      check_both("run", e2, e5);
      if (done2 && dn2 < 0) dn2 = cyc - rd0;
      if (done5 && dn5 < 0) dn5 = cyc - rd0;
    end
    stall = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("lat_bf2", 32'(dn2), 32'(62 + stall_n));
    chk("lat_bf5", 32'(dn5), 32'(71 + stall_n));
  endtask

  initial begin
    logic [20:0] idle;
    int st_t, st_n;
    idle = pk(C_IDLE, C_IDLE, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; stall = 1'b0;
    tick();
    tick();
    check_both("reset", idle, idle);
    rst = 1'b0;
    repeat (20) begin
      in_valid = 1'($urandom);
      tick();
      check_both("idle", idle, idle);
    end
    in_valid = 1'b0;

`ifdef SEQ_CTRL_STALL_EN
    do_xfer(-1, 3, 3);
`else
    do_xfer(-1, -1, 0);
`endif
    do_xfer(32, -1, 0);
    do_xfer(-1, -1, 0);
    for (int i = 0; i < 3; i++) begin
`ifdef SEQ_CTRL_STALL_EN
      st_t = int'($urandom_range(1, 6));
      st_n = int'($urandom_range(1, 4));
`else
      st_t = -1;
      st_n = 0;
`endif
      do_xfer(-1, st_t, st_n);
    end
    do_xfer(int'($urandom_range(1, 60)), -1, 0);
    do_xfer(-1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
